except_commit: RTL and testbench

Consumes the arbitrated exception/ERET request from the memory-stage exception unit and carries it out: it commits the CP0 side effects (EPC, Cause.BD, Cause.ExcCode, Status.EXL/ERL), flushes the pipeline and redirects fetch through a valid/ready handshake. In the other direction, it produces the exception unit's `interrupt_req` vector from raw asynchronous hardware interrupt lines. It sits between the exception unit, CP0 and the fetch stage.

---
 rtl/cpu_defs.sv | 37 +++
 rtl/int_sync.sv | 32 +++
 rtl/except_commit.sv | 129 ++++++++++++
 tb/tb_except_commit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU types: virtual addresses, exception request and exception codes
package cpu_defs;

  typedef logic [31:0] virt_t;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  typedef struct packed {
    logic       valid;
    logic       eret;
    logic [4:0] code;
    virt_t      pc;
    logic       delayslot;
    virt_t      except_vec;
  } except_req_t;

  // Request as held by the commit unit once accepted.
  typedef struct packed {
    logic       is_eret;
    logic [4:0] code;
    virt_t      pc;
    logic       delayslot;
    virt_t      target;
  } commit_req_t;

  // A delay-slot fault restarts at the branch, one word back (modulo 2^32).
  function automatic virt_t epc_of(virt_t pc, logic delayslot);
    return delayslot ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - multi-bit flop-chain synchronizer, async active-low reset to 0
module int_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/except_commit.sv
// rtl/except_commit.sv - commits exception/ERET side effects to CP0, flushes and redirects fetch
module except_commit
  import cpu_defs::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  except_req_t except_req,
  input  logic        status_exl,
  input  logic        status_erl,
  input  logic [7:0]  int_mask,
  input  logic [1:0]  sw_int,
  input  logic [5:0]  hw_int,
  input  logic        timer_int,
  output logic [7:0]  interrupt_req,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        cp0_we,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_upd_epc,
  output logic        cp0_set_exl,
  output logic        cp0_clr_exl,
  output logic        cp0_clr_erl,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_REDIRECT
  } state_e;

  state_e      state_q, state_d;
  commit_req_t req_q, req_d;
  logic [7:0]  interrupt_req_q, interrupt_req_d;
  logic [5:0]  hw_sync;

  int_sync #(
    .WIDTH (6),
    .STAGES(SYNC_STAGES)
  ) u_hw_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (hw_int),
    .q    (hw_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      req_q           <= '0;
      interrupt_req_q <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      interrupt_req_q <= interrupt_req_d;
    end
  end

  // Requests arriving outside IDLE are stale (pipeline already flushed) and dropped.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (except_req.valid) begin
          state_d           = ST_COMMIT;
          req_d.is_eret     = except_req.eret;
          req_d.code        = except_req.code;
          req_d.pc          = except_req.pc;
          req_d.delayslot   = except_req.delayslot;
          req_d.target      = except_req.except_vec;
        end
      end
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flush          = 1'b0;
    cp0_we         = 1'b0;
    cp0_upd_epc    = 1'b0;
    cp0_epc        = '0;
    cp0_bd         = 1'b0;
    cp0_exccode    = '0;
    cp0_set_exl    = 1'b0;
    cp0_clr_exl    = 1'b0;
    cp0_clr_erl    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (state_q == ST_COMMIT) begin
      flush  = 1'b1;
      cp0_we = 1'b1;
      if (req_q.is_eret) begin
        cp0_clr_erl = status_erl;
        cp0_clr_exl = !status_erl;
      end else begin
        cp0_set_exl = 1'b1;
        cp0_exccode = req_q.code;
        // A nested exception keeps the original EPC/BD.
        if (!status_exl) begin
          cp0_upd_epc = 1'b1;
          cp0_epc     = epc_of(req_q.pc, req_q.delayslot);
          cp0_bd      = req_q.delayslot;
        end
      end
    end
    if (state_q == ST_REDIRECT) begin
      redirect_valid = 1'b1;
      redirect_pc    = req_q.target;
    end
  end

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    interrupt_req_d = {hw_sync[5] | timer_int, hw_sync[4:0], sw_int} & int_mask;
  end

  assign interrupt_req = interrupt_req_q;

endmodule

// File: tb/tb_except_commit.sv
// tb/tb_except_commit.sv - scoreboard bench for except_commit with randomized stimulus
module tb_except_commit;
  import cpu_defs::*;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  except_req_t except_req;
  logic        status_exl, status_erl;
  logic [7:0]  int_mask;
  logic [1:0]  sw_int;
  logic [5:0]  hw_int;
  logic        timer_int;
  logic [7:0]  interrupt_req;
  logic        flush, redirect_valid, redirect_ready, cp0_we, cp0_bd, cp0_upd_epc;
  logic [31:0] redirect_pc, cp0_epc;
  logic [4:0]  cp0_exccode;
  logic        cp0_set_exl, cp0_clr_exl, cp0_clr_erl, busy;

  always #5 clk = ~clk;

  except_commit #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .except_req(except_req),
    .status_exl(status_exl), .status_erl(status_erl), .int_mask(int_mask),
    .sw_int(sw_int), .hw_int(hw_int), .timer_int(timer_int),
    .interrupt_req(interrupt_req), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .cp0_we(cp0_we), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd), .cp0_exccode(cp0_exccode),
    .cp0_upd_epc(cp0_upd_epc), .cp0_set_exl(cp0_set_exl), .cp0_clr_exl(cp0_clr_exl),
    .cp0_clr_erl(cp0_clr_erl), .busy(busy)
  );

  typedef struct {
    logic        upd;
    logic [31:0] epc;
    logic        bd;
    logic        is_eret;
    logic [4:0]  code;
    logic        set_exl, clr_exl, clr_erl;
  } exp_cp0_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_cp0_t    cq[$];
  logic [31:0] rq[$];
  logic [5:0]  hwq[$];
  logic [7:0]  exp_int;
  exp_cp0_t    mon_e;

  // Reference state: accepted request and cycles elapsed since acceptance.
  bit          m_busy, m_pending;
  int          m_age;
  bit          m_eret, m_ds;
  logic [4:0]  m_code;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pending = 0; m_age = 0;
    cq.delete(); rq.delete(); hwq.delete();
    repeat (SYNC_STAGES) hwq.push_back(6'h0);
    exp_int = 8'h0;
  endtask

  task automatic cycle(input bit v, input bit eret, input logic [4:0] code, input logic [31:0] pc,
                       input bit ds, input logic [31:0] vec, input bit exl, input bit erl, input bit rdy);
    exp_cp0_t   e;
    logic [5:0] s;
    except_req.valid      = v;
    except_req.eret       = eret;
    except_req.code       = code;
    except_req.pc         = pc;
    except_req.delayslot  = ds;
    except_req.except_vec = vec;
    status_exl     = exl;
    status_erl     = erl;
    redirect_ready = rdy;
    // Commit-cycle expectation uses the status values present during that cycle.
    if (m_pending) begin
      e.is_eret = m_eret;
      e.code    = m_code;
      e.set_exl = !m_eret;
      e.upd     = !m_eret && !exl;
      e.epc     = m_ds ? m_pc - 32'd4 : m_pc;
      e.bd      = m_ds;
      e.clr_erl = m_eret && erl;
      e.clr_exl = m_eret && !erl;
      cq.push_back(e);
      m_pending = 0;
    end
    @(posedge clk);
    s = hwq.pop_front();
    hwq.push_back(hw_int);
    exp_int = {s[5] | timer_int, s[4:0], sw_int} & int_mask;
    if (m_busy) begin
      m_age++;
      if (m_age >= 2 && rdy) m_busy = 0;
    end else if (v) begin
      m_busy = 1; m_age = 0; m_pending = 1;
      m_eret = eret; m_code = code; m_pc = pc; m_ds = ds;
      rq.push_back(vec);
    end
    #1;
  endtask

  task automatic idle(input int n, input bit exl, input bit erl, input bit rdy);
    repeat (n) cycle(0, 0, 5'h0, 32'h0, 0, 32'h0, exl, erl, rdy);
  endtask

  task automatic check_all_zero();
    chk("rst_flush", flush, 0);
    chk("rst_cp0_we", cp0_we, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_cp0_epc", cp0_epc, 0);
    chk("rst_cp0_flags", {cp0_bd, cp0_upd_epc, cp0_set_exl, cp0_clr_exl, cp0_clr_erl}, 0);
    chk("rst_cp0_exccode", cp0_exccode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_interrupt_req", interrupt_req, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("interrupt_req", interrupt_req, exp_int);
      chk("busy", busy, m_busy);
      chk("cp0_we_timing", cp0_we, m_busy && m_age == 0);
      chk("redirect_valid_timing", redirect_valid, m_busy && m_age >= 1);
      chk("flush_eq_we", flush, cp0_we);
      if (cp0_we) begin
        if (cq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_commit: got cp0_we=1 expected no commit");
        end else begin
          mon_e = cq.pop_front();
          chk("cp0_set_exl", cp0_set_exl, mon_e.set_exl);
          chk("cp0_clr_exl", cp0_clr_exl, mon_e.clr_exl);
          chk("cp0_clr_erl", cp0_clr_erl, mon_e.clr_erl);
          if (!mon_e.is_eret) begin
            chk("cp0_exccode", cp0_exccode, mon_e.code);
            chk("cp0_upd_epc", cp0_upd_epc, mon_e.upd);
            if (mon_e.upd) begin
              chk("cp0_epc", cp0_epc, mon_e.epc);
              chk("cp0_bd", cp0_bd, mon_e.bd);
            end
          end else begin
            chk("cp0_upd_epc_eret", cp0_upd_epc, 0);
          end
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_redirect: got redirect_valid=1 expected none");
        end else begin
          chk("redirect_pc", redirect_pc, rq[0]);
          if (redirect_ready) void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    except_req = '0;
    status_exl = 0; status_erl = 0; redirect_ready = 0;
    int_mask = 8'h0; sw_int = 2'b0; hw_int = 6'h0; timer_int = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    rst_n = 1'b1;

    // Plain exception, not in a delay slot.
    cycle(1, 0, EXCCODE_OV, 32'hBFC00100, 0, 32'hBFC00380, 0, 0, 1);
    chk("ex_flush", flush, 1);
    chk("ex_we", cp0_we, 1);
    chk("ex_upd", cp0_upd_epc, 1);
    chk("ex_epc", cp0_epc, 32'hBFC00100);
    chk("ex_bd", cp0_bd, 0);
    chk("ex_code", cp0_exccode, 5'h0C);
    chk("ex_set_exl", cp0_set_exl, 1);
    idle(1, 0, 0, 1);
    chk("ex_rv", redirect_valid, 1);
    chk("ex_rpc", redirect_pc, 32'hBFC00380);
    idle(1, 0, 0, 1);

    // Delay slot, then EPC wrap at address zero.
    cycle(1, 0, EXCCODE_RI, 32'h80000004, 1, 32'h80000180, 0, 0, 1);
    chk("ds_epc", cp0_epc, 32'h80000000);
    chk("ds_bd", cp0_bd, 1);
    idle(2, 0, 0, 1);
    cycle(1, 0, EXCCODE_ADEL, 32'h00000000, 1, 32'h80000180, 0, 0, 1);
    chk("wrap_epc", cp0_epc, 32'hFFFFFFFC);
    idle(2, 0, 0, 1);

    // Nested exception keeps EPC.
    cycle(1, 0, EXCCODE_SYS, 32'h80001000, 0, 32'h80000180, 1, 0, 1);
    chk("nest_we", cp0_we, 1);
    chk("nest_upd", cp0_upd_epc, 0);
    chk("nest_set_exl", cp0_set_exl, 1);
    idle(1, 1, 0, 1);
    chk("nest_rv", redirect_valid, 1);
    idle(1, 1, 0, 1);

    // ERET with ERL clear, then set.
    cycle(1, 1, 5'h0, 32'h0, 0, 32'h80001234, 1, 0, 1);
    chk("eret_clr_exl", cp0_clr_exl, 1);
    chk("eret_clr_erl", cp0_clr_erl, 0);
    idle(1, 1, 0, 1);
    chk("eret_rpc", redirect_pc, 32'h80001234);
    idle(1, 1, 0, 1);
    cycle(1, 1, 5'h0, 32'h0, 0, 32'h80005678, 0, 1, 1);
    chk("eret_erl_clr_erl", cp0_clr_erl, 1);
    chk("eret_erl_clr_exl", cp0_clr_exl, 0);
    idle(2, 0, 1, 1);

    // Backpressure with a stale request injected while stalled.
    cycle(1, 0, EXCCODE_BP, 32'h80000100, 0, 32'h80000180, 0, 0, 0);
    idle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(i == 2, 0, EXCCODE_ADES, 32'h00001000, 0, 32'hDEAD0000, 0, 0, 0);
      chk("bp_rv", redirect_valid, 1);
      chk("bp_rpc", redirect_pc, 32'h80000180);
      chk("bp_no_flush", flush, 0);
    end
    idle(1, 0, 0, 1);
    chk("bp_idle", busy, 0);
    idle(2, 0, 0, 1);

    // Reset while in REDIRECT.
    cycle(1, 0, EXCCODE_OV, 32'h80002000, 0, 32'h80000180, 0, 0, 0);
    idle(2, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    except_req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3, 0, 0, 1);

    // Interrupt paths.
    int_mask = 8'h84;
    idle(3, 0, 0, 1);
    hw_int = 6'h20;
    idle(1, 0, 0, 1); chk("hw_edge1", interrupt_req, 8'h00);
    idle(1, 0, 0, 1); chk("hw_edge2", interrupt_req, 8'h00);
    idle(1, 0, 0, 1); chk("hw_edge3", interrupt_req, 8'h80);
    hw_int = 6'h00;
    idle(4, 0, 0, 1); chk("hw_clear", interrupt_req, 8'h00);
    timer_int = 1;
    idle(1, 0, 0, 1); chk("timer", interrupt_req, 8'h80);
    timer_int = 0; sw_int = 2'b01;
    idle(2, 0, 0, 1); chk("sw_masked", interrupt_req, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) begin
        int_mask  = 8'($urandom);
        hw_int    = 6'($urandom);
        sw_int    = 2'($urandom);
        timer_int = 1'($urandom);
      end
      cycle($urandom_range(2) == 0, $urandom_range(3) == 0, 5'($urandom),
            ($urandom_range(7) == 0) ? 32'h0 : $urandom, 1'($urandom), $urandom,
            1'($urandom), 1'($urandom), $urandom_range(2) != 0);
    end

    idle(4, 0, 0, 1);
    chk("cq_drained", cq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
